controlador_entradas_sinc: RTL and testbench

Parametrised, clocked successor to the combinational switch-to-operand controller. It synchronises `2*WIDTH` switch inputs and a load pushbutton, optionally debounces the button, and captures the switches into operands `A` and `B` on each accepted press. It presents the captured operands with a valid/ack handshake to the downstream ALU/display logic. It sits between the board I/O pins and the arithmetic core.

---
 rtl/controlador_entradas_sinc_if.sv | 47 ++++
 rtl/controlador_entradas_sinc.sv | 177 +++++++++++++++++
 tb/tb_controlador_entradas_sinc.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_entradas_sinc_if.sv
// ----------------------------------------------------------------------------
// controlador_entradas_sinc_if
// Bundles the board-facing inputs and the operand handshake of
// controlador_entradas_sinc into one port.
//   sw       : raw switch levels, 2*WIDTH bits, asynchronous to clk
//   btn_load : raw load pushbutton, active-high, asynchronous to clk
//   ack      : consumer has taken A/B
//   A, B     : captured operands (low / high half of the switch bus)
//   valid    : A/B hold an unconsumed capture
//   overrun  : one-cycle pulse when a press is dropped
// Modports:
//   master : the controller (drives A, B, valid, overrun)
//   slave  : board/consumer side (drives sw, btn_load, ack)
// ----------------------------------------------------------------------------
interface controlador_entradas_sinc_if #(
   parameter int unsigned WIDTH = 8
);

   logic [2*WIDTH-1:0] sw;
   logic               btn_load;
   logic               ack;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic               valid;
   logic               overrun;

   modport master (
      input  sw,
      input  btn_load,
      input  ack,
      output A,
      output B,
      output valid,
      output overrun
   );

   modport slave (
      output sw,
      output btn_load,
      output ack,
      input  A,
      input  B,
      input  valid,
      input  overrun
   );

endinterface

// File: rtl/controlador_entradas_sinc.sv
// ----------------------------------------------------------------------------
// controlador_entradas_sinc
// Synchronises the operand switches and the load button, optionally debounces
// the button, and captures the switches into operands A/B on every accepted
// press. The captured pair is offered downstream with a valid/ack handshake;
// a press that arrives while the previous pair is still unconsumed is dropped
// and flagged with a one-cycle overrun pulse.
//
// Optional feature: define CTRL_ENTRADAS_DEBOUNCE_EN to require
// DEBOUNCE_CYCLES consecutive stable cycles before a button level change is
// accepted. Without it, a level is accepted as soon as it leaves the
// synchroniser.
//
// Parameters:
//   WIDTH           : operand width; the switch bus is 2*WIDTH
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level (>= 2)
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : controlador_entradas_sinc_if master modport
//           (sw, btn_load, ack in; A, B, valid, overrun out, all registered)
// ----------------------------------------------------------------------------
module controlador_entradas_sinc #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input logic                         clk,
   input logic                         rst_n,
   controlador_entradas_sinc_if.master bus
);

   localparam int unsigned SW_W = 2 * WIDTH;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESSED = 1'b1
   } btn_state_e;

   // Parameter range check
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("controlador_entradas_sinc: DEBOUNCE_CYCLES must be >= 2");
   end

   // Synchroniser stages
   logic [SW_W-1:0]  sw_s1_q;
   logic [SW_W-1:0]  sw_s_q;
   logic             btn_s1_q;
   logic             btn_s_q;

   // Button state machine
   btn_state_e       state_q;
   btn_state_e       state_d;

   // Operand / handshake registers
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_d;
   logic             valid_q;
   logic             valid_d;
   logic             overrun_q;
   logic             overrun_d;

   // Combinational helpers
   logic             level_diff_c;
   logic             accept_c;
   logic             press_c;

   // Two-flop synchronisers for the switches and the button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1_q  <= '0;
         sw_s_q   <= '0;
         btn_s1_q <= 1'b0;
         btn_s_q  <= 1'b0;
      end else begin
         sw_s1_q  <= bus.sw;
         sw_s_q   <= sw_s1_q;
         btn_s1_q <= bus.btn_load;
         btn_s_q  <= btn_s1_q;
      end
   end

   // Synchronised button disagrees with the level the FSM currently holds
   assign level_diff_c = (btn_s_q != (state_q == PRESSED));

`ifdef CTRL_ENTRADAS_DEBOUNCE_EN
   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count consecutive disagreeing cycles; accept once the count is full.
   // Any agreeing cycle restarts the count, so short glitches are absorbed.
   always_comb begin
      cnt_d    = cnt_q;
      accept_c = 1'b0;
      if (cnt_q == CNT_MAX) begin
         accept_c = 1'b1;
         cnt_d    = '0;
      end else if (level_diff_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // Debounce counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Level accepted as soon as it differs after synchronisation
   assign accept_c = level_diff_c;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   // Next state, press event, capture and handshake
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      press_c   = 1'b0;

      // Only the released->pressed transition is an event
      if (accept_c) begin
         if (state_q == IDLE) begin
            state_d = PRESSED;
            press_c = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end

      // An ack in the same cycle frees the slot, so the new press is taken
      if (press_c) begin
         if (!valid_q || bus.ack) begin
            a_d     = sw_s_q[WIDTH-1:0];
            b_d     = sw_s_q[SW_W-1:WIDTH];
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && bus.ack) begin
         valid_d = 1'b0;
      end
   end

   assign bus.A       = a_q;
   assign bus.B       = b_q;
   assign bus.valid   = valid_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_controlador_entradas_sinc.sv
// ----------------------------------------------------------------------------
// tb_controlador_entradas_sinc
// Self-checking bench for controlador_entradas_sinc (WIDTH=8,
// DEBOUNCE_CYCLES=4). A behavioural model derives the outputs from the
// sampled input history (a press is accepted when the synchronised button
// has disagreed with the held level over a full window of cycles) and is
// compared against the DUT every cycle. Directed scenarios add literal
// expectations. Works with CTRL_ENTRADAS_DEBOUNCE_EN defined or not.
// ----------------------------------------------------------------------------
module tb_controlador_entradas_sinc;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DB    = 4;
   localparam int          MAXE  = 8192;
`ifdef CTRL_ENTRADAS_DEBOUNCE_EN
   localparam int LAT = 3 + DB;
`else
   localparam int LAT = 3;
`endif

   logic clk;
   logic rst_n;

   controlador_entradas_sinc_if #(.WIDTH(WIDTH)) bus ();

   controlador_entradas_sinc #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // bl[k]/swv[k]: inputs sampled at edge k since reset (index 0 = reset value)
   bit                 bl  [0:MAXE-1];
   bit [2*WIDTH-1:0]   swv [0:MAXE-1];
   int                 e;
   int                 m_last;
   bit                 m_lvl;
   bit                 m_valid;
   bit                 m_over;
   bit [WIDTH-1:0]     m_A;
   bit [WIDTH-1:0]     m_B;

   // Synchronised button value seen just after edge k
   function automatic bit bs(input int k);
      return (k >= 1) ? bl[k-1] : 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e       = 0;
         m_last  = 0;
         m_lvl   = 1'b0;
         m_valid = 1'b0;
         m_over  = 1'b0;
         m_A     = '0;
         m_B     = '0;
         bl[0]   = 1'b0;
         swv[0]  = '0;
      end else if (e < MAXE - 1) begin
         bit acc;
         bit press;
         e++;
         bl[e]  = bus.btn_load;
         swv[e] = bus.sw;
         acc    = 1'b0;
`ifdef CTRL_ENTRADAS_DEBOUNCE_EN
         // Window of DB samples, all after the last acceptance, all differing
         if (e - DB - 1 >= m_last) begin
            acc = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
               if (bs(e - j) == m_lvl) acc = 1'b0;
         end
`else
         if (e - 1 >= m_last) acc = (bs(e - 1) != m_lvl);
`endif
         press = acc && !m_lvl;
         if (acc) begin
            m_lvl  = ~m_lvl;
            m_last = e;
         end
         m_over = 1'b0;
         if (press) begin
            if (!m_valid || bus.ack) begin
               m_A     = swv[e-2][WIDTH-1:0];
               m_B     = swv[e-2][2*WIDTH-1:WIDTH];
               m_valid = 1'b1;
            end else begin
               m_over = 1'b1;
            end
         end else if (m_valid && bus.ack) begin
            m_valid = 1'b0;
         end
         #1;
         chk("model_A", 32'(bus.A), 32'(m_A));
         chk("model_B", 32'(bus.B), 32'(m_B));
         chk("model_valid", 32'(bus.valid), 32'(m_valid));
         chk("model_overrun", 32'(bus.overrun), 32'(m_over));
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
   endtask

   int pat [7] = '{1, 1, 1, 0, 1, 1, 0};

   initial begin
      rst_n        = 1'b0;
      bus.sw       = '0;
      bus.btn_load = 1'b0;
      bus.ack      = 1'b0;
      tick(3);
      chk("reset_A", 32'(bus.A), 32'h0);
      chk("reset_B", 32'(bus.B), 32'h0);
      chk("reset_valid", 32'(bus.valid), 32'h0);
      chk("reset_overrun", 32'(bus.overrun), 32'h0);
      rst_n = 1'b1;
      tick(2);

      // Basic capture
      @(negedge clk);
      bus.sw       = 16'hF0AA;
      bus.btn_load = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         #2;
         if (k == LAT - 1) chk("basic_pre_valid", 32'(bus.valid), 32'h0);
      end
      chk("basic_valid", 32'(bus.valid), 32'h1);
      chk("basic_A", 32'(bus.A), 32'hAA);
      chk("basic_B", 32'(bus.B), 32'hF0);
      ack_pulse();
      chk("ack_valid", 32'(bus.valid), 32'h0);
      chk("ack_A_kept", 32'(bus.A), 32'hAA);
      chk("ack_B_kept", 32'(bus.B), 32'hF0);
      bus.btn_load = 1'b0;
      tick(12);

      // Bounce rejection
      bus.sw = 16'h7788;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.btn_load = pat[i][0];
      end
      @(negedge clk);
      bus.btn_load = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         #2;
`ifdef CTRL_ENTRADAS_DEBOUNCE_EN
         if (k == LAT - 1) chk("bounce_pre_valid", 32'(bus.valid), 32'h0);
`endif
      end
`ifdef CTRL_ENTRADAS_DEBOUNCE_EN
      chk("bounce_valid", 32'(bus.valid), 32'h1);
      chk("bounce_A", 32'(bus.A), 32'h88);
`endif
      ack_pulse();
      bus.btn_load = 1'b0;
      tick(12);

      // Overrun
      @(negedge clk);
      bus.sw       = 16'h0102;
      bus.btn_load = 1'b1;
      tick(LAT + 2);
      bus.btn_load = 1'b0;
      tick(12);
      bus.sw       = 16'h0304;
      bus.btn_load = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         #2;
      end
      chk("ovr_pulse", 32'(bus.overrun), 32'h1);
      chk("ovr_A", 32'(bus.A), 32'h02);
      chk("ovr_B", 32'(bus.B), 32'h01);
      chk("ovr_valid", 32'(bus.valid), 32'h1);
      @(posedge clk);
      #2;
      chk("ovr_pulse_end", 32'(bus.overrun), 32'h0);
      @(negedge clk);
      bus.btn_load = 1'b0;
      tick(12);

      // Simultaneous ack and press (valid still 1 from the overrun case)
      @(negedge clk);
      bus.sw       = 16'h5566;
      bus.btn_load = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         #2;
         if (k == LAT - 1) bus.ack = 1'b1;
      end
      chk("sim_A", 32'(bus.A), 32'h66);
      chk("sim_B", 32'(bus.B), 32'h55);
      chk("sim_valid", 32'(bus.valid), 32'h1);
      chk("sim_overrun", 32'(bus.overrun), 32'h0);
      bus.ack = 1'b0;

      // Async reset mid-operation, button held high through release
      tick(3);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_A", 32'(bus.A), 32'h0);
      chk("arst_B", 32'(bus.B), 32'h0);
      chk("arst_valid", 32'(bus.valid), 32'h0);
      chk("arst_overrun", 32'(bus.overrun), 32'h0);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         #2;
         if (k == LAT - 1) chk("arst_pre_valid", 32'(bus.valid), 32'h0);
      end
      chk("arst_recap_valid", 32'(bus.valid), 32'h1);
      chk("arst_recap_A", 32'(bus.A), 32'h66);
      chk("arst_recap_B", 32'(bus.B), 32'h55);
      ack_pulse();
      bus.btn_load = 1'b0;
      tick(12);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) bus.btn_load = ~bus.btn_load;
         bus.sw  = 16'($urandom);
         bus.ack = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      bus.ack = 1'b0;
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
